// File: rtl/mouse_link_ctrl.sv
// PS/2 mouse link sequencer: runs the FF/FA/AA/00/F4/FA power-up handshake with
// retry/timeout, then frames the streamed 3-byte packets for the decoder.
module mouse_link_ctrl #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxReady,
   input  logic [7:0] i_rxData,
   input  logic       i_txBusy,
   input  logic       i_txDone,
   output logic       o_txReq,
   output logic [7:0] o_txData,
   output logic       o_mouseReady,
   output logic [7:0] o_mouseData,
   output logic [1:0] o_byteIdx,
   output logic       o_initDone,
   output logic       o_initFail,
   output logic [1:0] o_retryCount
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_SEND_RST  = 3'd0;
   localparam logic [2:0] S_WAIT_ACK1 = 3'd1;
   localparam logic [2:0] S_WAIT_BAT  = 3'd2;
   localparam logic [2:0] S_WAIT_ID   = 3'd3;
   localparam logic [2:0] S_SEND_EN   = 3'd4;
   localparam logic [2:0] S_WAIT_ACK2 = 3'd5;
   localparam logic [2:0] S_STREAM    = 3'd6;
   localparam logic [2:0] S_FAIL      = 3'd7;

   logic [2:0]    r_state;
   logic          r_sent;
   logic [TW-1:0] r_timer;
   logic [1:0]    r_idx;
   logic [1:0]    r_retry;
   logic          r_txReq;
   logic [7:0]    r_txData;
   logic          r_mouseReady;
   logic [7:0]    r_mouseData;
   logic [1:0]    r_byteIdx;

   logic [2:0]    w_next;
   logic          w_enter;
   logic          w_accept;
   logic          w_txReq;
   logic          w_emit;
   logic          w_fail;
   logic [1:0]    w_idx_next;
   logic [1:0]    w_retry_next;
   logic          w_tmo;

   assign w_tmo = (r_timer == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_next       = r_state;
      w_enter      = 1'b0;
      w_accept     = 1'b0;
      w_txReq      = 1'b0;
      w_emit       = 1'b0;
      w_fail       = 1'b0;
      w_idx_next   = r_idx;
      w_retry_next = r_retry;
      case (r_state)
         S_SEND_RST, S_SEND_EN: begin
            // rx bytes are not looked at until the command has gone out
            if (r_sent && i_txDone) begin
               w_next  = (r_state == S_SEND_RST) ? S_WAIT_ACK1 : S_WAIT_ACK2;
               w_enter = 1'b1;
            end else if (!r_sent && !i_txBusy) begin
               w_txReq = 1'b1;
            end else if (w_tmo) begin
               w_fail = 1'b1;
            end
         end
         S_WAIT_ACK1, S_WAIT_ACK2: begin
            if (i_rxReady) begin
               w_accept = 1'b1;
               if (i_rxData == 8'hFA) begin
                  w_next  = (r_state == S_WAIT_ACK1) ? S_WAIT_BAT : S_STREAM;
                  w_enter = 1'b1;
               end else if (i_rxData == 8'hFE) begin
                  w_next  = (r_state == S_WAIT_ACK1) ? S_SEND_RST : S_SEND_EN;
                  w_enter = 1'b1;
               end else begin
                  w_fail = 1'b1;
               end
            end else if (w_tmo) begin
               w_fail = 1'b1;
            end
         end
         S_WAIT_BAT, S_WAIT_ID: begin
            if (i_rxReady) begin
               w_accept = 1'b1;
               if (i_rxData == ((r_state == S_WAIT_BAT) ? 8'hAA : 8'h00)) begin
                  w_next  = (r_state == S_WAIT_BAT) ? S_WAIT_ID : S_SEND_EN;
                  w_enter = 1'b1;
               end else begin
                  w_fail = 1'b1;
               end
            end else if (w_tmo) begin
               w_fail = 1'b1;
            end
         end
         S_STREAM: begin
            // first byte of a packet always has bit3 set; anything else is a resync drop
            if (i_rxReady) begin
               if (r_idx != 2'd0 || i_rxData[3]) begin
                  w_accept   = 1'b1;
                  w_emit     = 1'b1;
                  w_idx_next = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
               end
            end else if (w_tmo && r_idx != 2'd0) begin
               w_idx_next = 2'd0;
            end
         end
         default: ;
      endcase
      if (w_fail) begin
         w_retry_next = r_retry + 2'd1;
         w_next       = (w_retry_next == 2'(MAX_RETRY)) ? S_FAIL : S_SEND_RST;
         w_enter      = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state      <= S_SEND_RST;
         r_sent       <= 1'b0;
         r_timer      <= '0;
         r_idx        <= 2'd0;
         r_retry      <= 2'd0;
         r_txReq      <= 1'b0;
         r_txData     <= 8'h00;
         r_mouseReady <= 1'b0;
         r_mouseData  <= 8'h00;
         r_byteIdx    <= 2'd0;
      end else begin
         r_state      <= w_next;
         r_retry      <= w_retry_next;
         r_idx        <= w_enter ? 2'd0 : w_idx_next;
         r_timer      <= (w_enter || w_accept) ? '0 : r_timer + TW'(1);
         r_txReq      <= w_txReq;
         r_mouseReady <= w_emit;
         if (w_enter)
            r_sent <= 1'b0;
         else if (w_txReq)
            r_sent <= 1'b1;
         if (w_txReq)
            r_txData <= (r_state == S_SEND_EN) ? 8'hF4 : 8'hFF;
         if (w_emit) begin
            r_mouseData <= i_rxData;
            r_byteIdx   <= r_idx;
         end
      end
   end

   assign o_txReq      = r_txReq;
   assign o_txData     = r_txData;
   assign o_mouseReady = r_mouseReady;
   assign o_mouseData  = r_mouseData;
   assign o_byteIdx    = r_byteIdx;
   assign o_initDone   = (r_state == S_STREAM);
   assign o_initFail   = (r_state == S_FAIL);
   assign o_retryCount = r_retry;

endmodule

// File: tb/tb_mouse_link_ctrl.sv
// Directed bench for mouse_link_ctrl: handshake, framing, resync, NAK/retry,
// silent-mouse failure and mid-packet reset, with a txDone responder.
module tb_mouse_link_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxReady = 1'b0;
   logic [7:0] rxData = 8'h00;
   logic       txBusy = 1'b0;
   logic       txDone = 1'b0;
   logic       txReq, mouseReady, initDone, initFail;
   logic [7:0] txData, mouseData;
   logic [1:0] byteIdx, retryCount;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, n_tx = 0, n_done = 0, base = 0, gap = 0, cnt = 0;
   logic [7:0] last_tx = 8'h00;
   logic overlap = 1'b0;
   int tx_t[$];

   mouse_link_ctrl #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3)) dut (
      .i_clk(clk), .i_rst(rst), .i_rxReady(rxReady), .i_rxData(rxData),
      .i_txBusy(txBusy), .i_txDone(txDone), .o_txReq(txReq), .o_txData(txData),
      .o_mouseReady(mouseReady), .o_mouseData(mouseData), .o_byteIdx(byteIdx),
      .o_initDone(initDone), .o_initFail(initFail), .o_retryCount(retryCount));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model: txDone 5 clocks after each txReq
   initial forever begin
      @(posedge clk); #1;
      if (txReq) begin
         n_tx++; last_tx = txData; tx_t.push_back(cyc);
         repeat (5) @(posedge clk);
         #1 txDone = 1'b1;
         @(posedge clk); #1 txDone = 1'b0;
         n_done++;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (txReq && mouseReady) overlap = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic rx(input logic [7:0] b);
      rxReady = 1'b1; rxData = b;
      @(posedge clk); #2;
      rxReady = 1'b0;
   endtask

   task automatic wait_tx(input int n, input string tag);
      int c = 0;
      while (n_tx < n && c < 3000) begin @(posedge clk); #2; c++; end
      chk(tag, n_tx, n);
   endtask

   task automatic wait_done(input int n, input string tag);
      int c = 0;
      while (n_done < n && c < 3000) begin @(posedge clk); #2; c++; end
      chk(tag, n_done, n);
   endtask

   logic [7:0] s2_d [6] = '{8'h09, 8'h02, 8'h03, 8'h08, 8'h05, 8'h0A};
   logic [7:0] s3_d [3] = '{8'h09, 8'h01, 8'h01};

   initial begin
      // reset state
      idle(3);
      chk("rst_txReq", txReq, 0);
      chk("rst_txData", txData, 0);
      chk("rst_mr", mouseReady, 0);
      chk("rst_done_fail", {initDone, initFail}, 0);
      chk("rst_retry", retryCount, 0);

      // 1. happy path
      rst = 1'b1;
      wait_tx(1, "t1_tx1");
      chk("t1_FF", last_tx, 8'hFF);
      wait_done(1, "t1_done1");
      rx(8'hFA); rx(8'hAA); rx(8'h00);
      wait_tx(2, "t1_tx2");
      chk("t1_F4", last_tx, 8'hF4);
      wait_done(2, "t1_done2");
      chk("t1_notdone", initDone, 0);
      rx(8'hFA);
      chk("t1_initDone", initDone, 1);
      chk("t1_retry", retryCount, 0);

      // 2. stream framing, 1-clk latency
      for (int i = 0; i < 6; i++) begin
         rx(s2_d[i]);
         chk($sformatf("t2_b%0d", i), {mouseReady, byteIdx, mouseData},
             {1'b1, 2'(i % 3), s2_d[i]});
         idle(2);
      end

      // 3. resync drop
      rx(8'h02);
      chk("t3_drop", mouseReady, 0);
      for (int i = 0; i < 3; i++) begin
         rx(s3_d[i]);
         chk($sformatf("t3_b%0d", i), {mouseReady, byteIdx, mouseData},
             {1'b1, 2'(i), s3_d[i]});
      end

      // timeout mid-packet resets index, stays in STREAM
      rx(8'h09);
      chk("to_b0", {mouseReady, byteIdx}, {1'b1, 2'd0});
      idle(120);
      rx(8'h0A);
      chk("to_reidx", {mouseReady, byteIdx, mouseData}, {1'b1, 2'd0, 8'h0A});
      chk("to_stream", {initDone, retryCount}, {1'b1, 2'd0});

      // 6. reset mid-packet
      rx(8'h01);
      chk("t6_b1", {mouseReady, byteIdx}, {1'b1, 2'd1});
      rst = 1'b0;
      idle(1);
      chk("t6_outs", {txReq, txData, mouseReady, mouseData, byteIdx, initDone, initFail, retryCount}, 0);
      rst = 1'b1;
      wait_tx(3, "t6_tx");
      chk("t6_FF", last_tx, 8'hFF);
      wait_done(3, "t6_done");

      // 4. NAK then bad byte
      rx(8'hFE);
      chk("t4_nak_retry", retryCount, 0);
      wait_tx(4, "t4_tx_nak");
      chk("t4_FF1", last_tx, 8'hFF);
      wait_done(4, "t4_done1");
      rx(8'h55);
      chk("t4_bad_retry", retryCount, 1);
      wait_tx(5, "t4_tx_bad");
      chk("t4_FF2", last_tx, 8'hFF);
      wait_done(5, "t4_done2");

      // 5. silent mouse -> FAIL after three attempts
      base = n_tx;
      rst = 1'b0;
      idle(2);
      chk("t5_rst_retry", retryCount, 0);
      rst = 1'b1;
      cnt = 0;
      while (!initFail && cnt < 1500) begin idle(1); cnt++; end
      chk("t5_initFail", initFail, 1);
      chk("t5_ntx", n_tx - base, 3);
      chk("t5_retry", retryCount, 3);
      if (n_tx - base >= 2) begin
         gap = tx_t[base + 1] - tx_t[base];
         chk("t5_gap_ok", (gap >= 100 && gap <= 115), 1);
      end
      idle(300);
      chk("t5_no_more_tx", n_tx - base, 3);
      chk("t5_sticky", {initFail, initDone}, {1'b1, 1'b0});
      rx(8'hFA);
      chk("t5_rx_ignored", {initFail, mouseReady}, {1'b1, 1'b0});

      chk("excl_tx_mr", overlap, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
